uart_word_sender: RTL and testbench

Serializes one response word of up to four bytes onto a UART TX line, 8N1, least-significant byte first. Sits directly downstream of the control logic. It consumes `send_data_register`, `size_line` and `valid_data`, and returns `busy_sender_data`. Fixed responses such as 0x0D595342 therefore appear on the wire as "BSY\r".

---
 rtl/space_ctrl_pkg.sv | 6 +
 rtl/uart_tx_byte.sv | 62 ++++++
 rtl/uart_word_sender.sv | 61 ++++++
 tb/tb_uart_word_sender.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/space_ctrl_pkg.sv
// space_ctrl_pkg: UART frame constants and serializer state encoding shared by the TX and RX sides.
package space_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} uart_state_t;
  localparam int UART_FRAME_BITS = 10;
  localparam int DEFAULT_CLKS_PER_BIT = 434;
endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 bit serializer. A start coinciding with o_byte_done chains straight into the next start bit.
module uart_tx_byte
  import space_ctrl_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int CNT_WIDTH    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic [7:0] i_byte,
  output logic       o_tx,
  output logic       o_byte_done
);
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(CLKS_PER_BIT - 1);
  uart_state_t          r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [2:0]           r_bit;
  logic [7:0]           r_byte;
  logic                 r_tx;
  logic                 w_tick;
  assign w_tick      = r_cnt == LAST;
  assign o_byte_done = r_state == STOP && w_tick;
  assign o_tx        = r_tx;
  // r_byte shifts right so r_byte[0] is always the next data bit to drive
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_byte  <= '0;
      r_tx    <= 1'b1;
    end else if (i_start && (r_state == IDLE || o_byte_done)) begin
      r_state <= START;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_byte  <= i_byte;
      r_tx    <= 1'b0;
    end else if (r_state != IDLE) begin
      r_cnt <= w_tick ? '0 : r_cnt + CNT_WIDTH'(1);
      if (w_tick) begin
        case (r_state)
          START: begin
            r_state <= DATA;
            r_tx    <= r_byte[0];
            r_byte  <= r_byte >> 1;
          end
          DATA: begin
            r_bit   <= r_bit + 3'd1;
            r_state <= r_bit == 3'd7 ? STOP : DATA;
            r_tx    <= r_bit == 3'd7 ? 1'b1 : r_byte[0];
            r_byte  <= r_byte >> 1;
          end
          default: begin
            r_state <= IDLE;
            r_tx    <= 1'b1;
          end
        endcase
      end
    end
  end
endmodule

// File: rtl/uart_word_sender.sv
// uart_word_sender: sends up to WORD_SIZE/8 bytes of a word LSB-first over 8N1 UART.
// A request may be accepted on the edge that finishes the previous word, keeping busy high.
module uart_word_sender
  import space_ctrl_pkg::*;
#(
  parameter int WORD_SIZE    = 32,
  parameter int SIZE_WORD    = 3,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] data_in,
  input  logic [SIZE_WORD-1:0] size_line,
  input  logic                 valid_data,
  output logic                 busy,
  output logic                 tx,
  output logic                 done
);
  localparam logic [SIZE_WORD-1:0] MAX_BYTES = SIZE_WORD'(WORD_SIZE / 8);
  logic [WORD_SIZE-1:0] r_shift, w_next_shift;
  logic [SIZE_WORD-1:0] r_count, w_size;
  logic                 r_busy, r_done;
  logic                 w_byte_done, w_word_end, w_accept, w_start;
  logic [7:0]           w_byte;
  assign w_size       = size_line > MAX_BYTES ? MAX_BYTES : size_line;
  assign w_word_end   = w_byte_done && r_count == SIZE_WORD'(1);
  assign w_accept     = valid_data && w_size != '0 && (!r_busy || w_word_end);
  assign w_next_shift = r_shift >> 8;
  assign w_start      = w_accept || (w_byte_done && !w_word_end);
  assign w_byte       = w_accept ? data_in[7:0] : w_next_shift[7:0];
  assign busy         = r_busy;
  assign done         = r_done;
  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT), .CNT_WIDTH(CNT_WIDTH)) u_tx (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_start),
    .i_byte     (w_byte),
    .o_tx       (tx),
    .o_byte_done(w_byte_done)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_word_end;
      if (w_accept) begin
        r_shift <= data_in;
        r_count <= w_size;
        r_busy  <= 1'b1;
      end else if (w_byte_done) begin
        r_shift <= w_next_shift;
        r_count <= r_count - SIZE_WORD'(1);
        r_busy  <= !w_word_end;
      end
    end
  end
endmodule

// File: tb/tb_uart_word_sender.sv
// tb_uart_word_sender: frame-arithmetic reference model plus an independent UART line decoder.
module tb_uart_word_sender;
  import space_ctrl_pkg::*;
  localparam int C = 4;
  logic        clk = 0, rst = 0, valid_data = 0;
  logic [31:0] data_in = '0;
  logic [2:0]  size_line = '0;
  logic        busy, tx, done;
  int          n_checks = 0, n_fail = 0;
  int          busy_cnt = 0, done_cnt = 0;
  bit          m_act = 0, m_done = 0;
  int          m_c = 0, m_start = 0, m_end = 0;
  logic [31:0] m_word = '0;
  logic [7:0]  exp_q[$], rx_q[$];

  uart_word_sender #(.WORD_SIZE(32), .SIZE_WORD(3), .CLKS_PER_BIT(C), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .size_line(size_line),
    .valid_data(valid_data), .busy(busy), .tx(tx), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Line level m cycles after acceptance: start bit, 8 data bits LSB-first, stop bit per byte.
  function automatic logic frame_bit(input logic [31:0] w, input int m);
    int idx = m / C;
    int b = idx / UART_FRAME_BITS;
    int p = idx % UART_FRAME_BITS;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return w[b * 8 + p - 1];
  endfunction

  task automatic model_edge();
    int n;
    m_done = m_act && m_c == m_end;
    if (m_done) m_act = 0;
    n = size_line > 3'd4 ? 4 : int'(size_line);
    if (valid_data && !m_act && n != 0) begin
      m_act   = 1;
      m_start = m_c;
      m_end   = m_c + n * UART_FRAME_BITS * C;
      m_word  = data_in;
      for (int i = 0; i < n; i++) exp_q.push_back(data_in[i * 8 +: 8]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    m_c++;
    if (rst) begin
      m_act  = 0;
      m_done = 0;
    end else model_edge();
    #1;
    check("tx", tx, m_act ? frame_bit(m_word, m_c - m_start) : 1'b1);
    check("busy", busy, m_act);
    check("done", done, m_done);
    busy_cnt += int'(busy);
    done_cnt += int'(done);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input logic [31:0] d, input logic [2:0] s);
    data_in = d;
    size_line = s;
    valid_data = 1;
    step();
    valid_data = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 1000) begin
      step();
      n++;
    end
    check("idle_timeout", busy, 0);
  endtask

  task automatic drain();
    check("rx_count", rx_q.size(), exp_q.size());
    while (rx_q.size() > 0 && exp_q.size() > 0) check("rx_byte", rx_q.pop_front(), exp_q.pop_front());
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic clear_counts();
    busy_cnt = 0;
    done_cnt = 0;
  endtask

  initial begin
    logic [7:0] b;
    forever begin
      @(negedge tx);
      repeat (C / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (C) @(negedge clk);
        b[i] = tx;
      end
      repeat (C) @(negedge clk);
      check("rx_stop", tx, 1);
      rx_q.push_back(b);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    run(3);
    rst = 0;
    run(2);
    clear_counts();
    send(32'h0D595342, 3'd4);
    wait_idle();
    run(3);
    check("full_busy_cycles", busy_cnt, 160);
    check("full_done_count", done_cnt, 1);
    check("full_bytes", {rx_q[3], rx_q[2], rx_q[1], rx_q[0]}, 32'h0D595342);
    drain();
    clear_counts();
    send(32'hDEADBEEF, 3'd0);
    run(20);
    check("empty_busy_cycles", busy_cnt, 0);
    check("empty_done_count", done_cnt, 0);
    drain();
    clear_counts();
    send(32'h0D0A4B4F, 3'd7);
    wait_idle();
    run(3);
    check("clamp_busy_cycles", busy_cnt, 160);
    check("clamp_bytes", {rx_q[3], rx_q[2], rx_q[1], rx_q[0]}, 32'h0D0A4B4F);
    drain();
    clear_counts();
    send(32'h0D595342, 3'd4);
    run(50);
    send(32'h0D0A2031, 3'd4);
    wait_idle();
    run(3);
    check("ignored_busy_cycles", busy_cnt, 160);
    check("ignored_done_count", done_cnt, 1);
    drain();
    clear_counts();
    data_in = 32'h0D0A2030;
    size_line = 3'd2;
    valid_data = 1;
    run(85);
    valid_data = 0;
    wait_idle();
    run(3);
    check("b2b_busy_cycles", busy_cnt, 160);
    check("b2b_done_count", done_cnt, 2);
    check("b2b_bytes", {rx_q[3], rx_q[2], rx_q[1], rx_q[0]}, 32'h20302030);
    drain();
    clear_counts();
    send(32'h0D595342, 3'd4);
    run(57);
    #2 rst = 1;
    #1;
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    clear_counts();
    run(2);
    rst = 0;
    run(60);
    check("rst_done_count", done_cnt, 0);
    rx_q.delete();
    exp_q.delete();
    clear_counts();
    send(32'hFFFFFF55, 3'd1);
    wait_idle();
    run(3);
    check("partial_busy_cycles", busy_cnt, 40);
    check("partial_byte", rx_q[0], 8'h55);
    drain();
    for (int k = 0; k < 12; k++) begin
      send($urandom, 3'($urandom_range(0, 7)));
      run($urandom_range(1, 120));
    end
    wait_idle();
    run(3);
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
